// File: rtl/regfile_pkg.sv
// Shared constants and types for the 64-bit register file.
package regfile_pkg;
  localparam int DATA_W  = 64;
  localparam int NREGS   = 32;
  localparam int ADDR_W  = 5;
  localparam int XZR_IDX = 31;

  typedef logic [DATA_W-1:0] reg_t;
endpackage

// File: rtl/regfile.sv
// Two-read, one-write register file X0..X30 with a hardwired-zero X31 (XZR).
// Reset, and power-up without any reset pulse, both give Xi = i.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int NREGS  = regfile_pkg::NREGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam logic [ADDR_W-1:0] XZR = ADDR_W'(XZR_IDX);

  // Each entry holds Xi XOR i, not Xi itself. Two-state storage starts at
  // zero, so the power-up contents read back as Xi = i without a reset.
  bit [DATA_W-1:0] delta [0:NREGS-2];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS - 1; i++) begin
        delta[i] <= '0;
      end
    end else if (we3 && (wa3 != XZR)) begin
      delta[wa3] <= wd3 ^ DATA_W'(wa3);
    end
  end

  always_comb begin
    rd1 = '0;
    if (ra1 != XZR) begin
      rd1 = delta[ra1] ^ DATA_W'(ra1);
    end
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != XZR) begin
      rd2 = delta[ra2] ^ DATA_W'(ra2);
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Directed testbench for regfile: readback, writes, XZR, reset and hold cases.
module tb_regfile;
  import regfile_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       we3 = 1'b0;
  logic [4:0] ra1 = '0;
  logic [4:0] ra2 = '0;
  logic [4:0] wa3 = '0;
  reg_t       wd3 = '0;
  reg_t       rd1;
  reg_t       rd2;

  int checks = 0;
  int failures = 0;

  regfile dut (
    .clk   (clk),
    .reset (reset),
    .we3   (we3),
    .ra1   (ra1),
    .ra2   (ra2),
    .wa3   (wa3),
    .wd3   (wd3),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input reg_t got, input reg_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_pair(input logic [4:0] a1, input logic [4:0] a2);
    ra1 = a1;
    ra2 = a2;
    #1;
  endtask

  initial begin
    #1;
    // power-up contents, no reset applied
    for (int i = 0; i < 31; i++) begin
      read_pair(5'(i), 5'(i));
      check($sformatf("init_rd1_x%0d", i), rd1, reg_t'(i));
      check($sformatf("init_rd2_x%0d", i), rd2, reg_t'(i));
    end
    read_pair(5'd31, 5'd31);
    check("init_rd1_xzr", rd1, 64'd0);
    check("init_rd2_xzr", rd2, 64'd0);

    // write X1 = 200; no bypass before the edge
    we3 = 1'b1; wa3 = 5'd1; wd3 = 64'd200;
    read_pair(5'd1, 5'd5);
    check("x1_before_edge", rd1, 64'd1);
    tick();
    check("x1_after_write", rd1, 64'd200);
    check("x5_unchanged", rd2, 64'd5);

    wa3 = 5'd10; wd3 = 64'd111;
    read_pair(5'd1, 5'd10);
    tick();
    check("x1_still_200", rd1, 64'd200);
    check("x10_after_write", rd2, 64'd111);

    // write to XZR is dropped
    wa3 = 5'd31; wd3 = 64'd999;
    read_pair(5'd31, 5'd0);
    tick();
    check("xzr_after_write", rd1, 64'd0);
    check("x0_after_xzr_write", rd2, 64'd0);
    we3 = 1'b0;
    read_pair(5'd1, 5'd10);
    check("x1_after_xzr_write", rd1, 64'd200);
    check("x10_after_xzr_write", rd2, 64'd111);
    read_pair(5'd30, 5'd29);
    check("x30_after_xzr_write", rd1, 64'd30);
    check("x29_after_xzr_write", rd2, 64'd29);

    // boundary registers X0 and X30 with wide data
    we3 = 1'b1; wa3 = 5'd0; wd3 = 64'hDEAD_BEEF_0123_4567;
    tick();
    wa3 = 5'd30; wd3 = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    we3 = 1'b0;
    read_pair(5'd0, 5'd30);
    check("x0_wide_write", rd1, 64'hDEAD_BEEF_0123_4567);
    check("x30_all_ones", rd2, 64'hFFFF_FFFF_FFFF_FFFF);
    read_pair(5'd30, 5'd30);
    check("same_addr_rd1", rd1, 64'hFFFF_FFFF_FFFF_FFFF);
    check("same_addr_rd2", rd2, 64'hFFFF_FFFF_FFFF_FFFF);

    // reset wins over a simultaneous write and discards earlier writes
    reset = 1'b1; we3 = 1'b1; wa3 = 5'd2; wd3 = 64'd77;
    tick();
    reset = 1'b0; we3 = 1'b0;
    read_pair(5'd2, 5'd1);
    check("x2_after_reset", rd1, 64'd2);
    check("x1_after_reset", rd2, 64'd1);
    read_pair(5'd10, 5'd30);
    check("x10_after_reset", rd1, 64'd10);
    check("x30_after_reset", rd2, 64'd30);
    read_pair(5'd0, 5'd31);
    check("x0_after_reset", rd1, 64'd0);
    check("xzr_after_reset", rd2, 64'd0);

    // write enable low holds every register
    we3 = 1'b0; wa3 = 5'd3; wd3 = 64'd55;
    read_pair(5'd3, 5'd4);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("x3_hold_cycle%0d", c), rd1, 64'd3);
    end
    check("x4_hold", rd2, 64'd4);

    // independent ports after a fresh write
    we3 = 1'b1; wa3 = 5'd7; wd3 = 64'd12345;
    tick();
    we3 = 1'b0;
    read_pair(5'd7, 5'd8);
    check("x7_port1", rd1, 64'd12345);
    check("x8_port2", rd2, 64'd8);
    read_pair(5'd8, 5'd7);
    check("x8_port1", rd1, 64'd8);
    check("x7_port2", rd2, 64'd12345);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
